// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: two-master arbiter in front of a single shared memory port.
// Master 0 is the CPU, which is stalled through cpu_enable while its request
// is outstanding; master 1 is a secondary master. Only one transaction is in
// flight at a time, and a stuck memory is cut off by a wait-cycle timeout.
//
// Optional define ARB_ROUND_ROBIN_EN: on simultaneous requests, grant the
// master that did not win last time. Without it, master 0 always wins ties
// and no last-grant state exists.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; pick a winner and latch its request fields
// ST_BUSY   | mem_req held with latched fields, waiting for mem_ack
// ST_DONE   | one-cycle ack (err too if timed out) to the winning master

module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [1:0]            m0_size,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [1:0]            m1_size,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,

    output logic                  cpu_enable
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wait-counter value seen in the last BUSY cycle that may still accept
    // mem_ack; the increment out of it makes the counter reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state;
    logic                  winner;      // 0 = m0, 1 = m1
    logic                  err_q;
    logic [7:0]            wait_cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [1:0]            lat_size;
    logic                  any_req;
    logic                  grant_m1;

    assign any_req = m0_req | m1_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;                   // winner of the most recent grant

    // Tie goes to the master that was not granted last time.
    always_comb begin
        grant_m1 = m1_req & (~m0_req | ~last_grant);
    end

    // Remember who won; reset value 1 lets m0 take the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= grant_m1;
        end
    end
`else
    // Fixed priority: m0 wins whenever it is requesting.
    always_comb begin
        grant_m1 = m1_req & ~m0_req;
    end
`endif

    // Transaction sequencing, request latching, timeout and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            winner    <= 1'b0;
            err_q     <= 1'b0;
            wait_cnt  <= 8'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= 2'd0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        winner    <= grant_m1;
                        lat_we    <= grant_m1 ? m1_we    : m0_we;
                        lat_addr  <= grant_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                        lat_size  <= grant_m1 ? m1_size  : m0_size;
                        err_q     <= 1'b0;
                        wait_cnt  <= 8'd0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        err_q <= 1'b0;
                        if (winner) begin
                            m1_rdata <= mem_rdata;
                        end else begin
                            m0_rdata <= mem_rdata;
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            // Memory never answered: abort with zeroed data.
                            err_q <= 1'b1;
                            if (winner) begin
                                m1_rdata <= '0;
                            end else begin
                                m0_rdata <= '0;
                            end
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory side: request only while BUSY; fields come straight from latches
    // so they cannot move during a transaction.
    always_comb begin
        mem_req   = (state == ST_BUSY);
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_size  = lat_size;
    end

    // Completion strobes to the winner only; CPU runs unless waiting on m0.
    always_comb begin
        m0_ack     = (state == ST_DONE) & ~winner;
        m1_ack     = (state == ST_DONE) &  winner;
        m0_err     = m0_ack & err_q;
        m1_err     = m1_ack & err_q;
        cpu_enable = ~m0_req | m0_ack;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter (TIMEOUT=4). A vector table drives single
// transactions with a scripted memory responder; completions are checked
// against a queue of expected {port, rdata, err}. Hand sequences cover
// spurious mem_ack, reset mid-transaction and simultaneous requests.
// Expected tie order depends on ARB_ROUND_ROBIN_EN.

module tb_cpu_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [1:0]  m0_size = 0, m1_size = 0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata = 0;
    logic        mem_ack = 0;
    logic        cpu_enable;

    // responder controls
    logic        force_ack = 0;
    logic        addr_mode = 0;
    int          resp_delay = 99;
    logic [31:0] resp_data = 0;
    int          busy_cyc = 0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          delay;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[7];
    logic [31:0] last_rd[2];

    cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_size(m0_size), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_size(m1_size), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_enable(cpu_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_m(input int p, input logic req, we, input logic [31:0] addr, wdata,
                         input logic [1:0] size);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = size;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = size;
        end
    endtask

    // Memory model: ack resp_delay cycles after mem_req first goes high.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ack = force_ack;
            if (force_ack) begin
                mem_rdata = 32'hFFFF_FFFF;
            end else if (mem_req) begin
                if (busy_cyc == resp_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = addr_mode ? (mem_addr ^ KEY) : resp_data;
                end
                busy_cyc++;
            end else begin
                busy_cyc = 0;
            end
        end
    end

    // Scoreboard: every ack pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (m0_ack || m1_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual m0_ack=%0d m1_ack=%0d required none (t=%0t)",
                         m0_ack, m1_ack, $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_port", {31'd0, m1_ack}, e.port);
                chk("sb_single_ack", {31'd0, m0_ack & m1_ack}, 0);
                chk("sb_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
                chk("sb_err", {31'd0, m1_ack ? m1_err : m0_err}, {31'd0, e.err});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int exp_len;
        exp_len = (v.delay + 1 < TO) ? v.delay + 1 : TO;
        resp_delay = v.delay;
        resp_data  = v.rdata;
        sb_q.push_back('{v.port, v.exp_rdata, v.exp_err});
        set_m(v.port, 1'b1, v.we, v.addr, v.wdata, v.size);
        for (int n = 0; n <= exp_len; n++) begin
            tick();
            chk("mem_req", {31'd0, mem_req}, (n < exp_len) ? 1 : 0);
            if (n < exp_len) begin
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_wdata", mem_wdata, v.wdata);
                chk("mem_size", {30'd0, mem_size}, {30'd0, v.size});
                chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
            end
            chk("own_ack", {31'd0, (v.port == 0) ? m0_ack : m1_ack}, (n == exp_len) ? 1 : 0);
            chk("other_ack", {31'd0, (v.port == 0) ? m1_ack : m0_ack}, 0);
            chk("cpu_enable", {31'd0, cpu_enable},
                (v.port != 0 || n == exp_len) ? 1 : 0);
        end
        set_m(v.port, 1'b0, v.we, v.addr, v.wdata, v.size);
        tick();
        chk("idle_mem_req", {31'd0, mem_req}, 0);
        chk("own_rdata_hold", (v.port == 0) ? m0_rdata : m1_rdata, v.exp_rdata);
        chk("other_rdata_hold", (v.port == 0) ? m1_rdata : m0_rdata, last_rd[1 - v.port]);
        last_rd[v.port] = v.exp_rdata;
    endtask

    task automatic master_seq(input int p, input logic [31:0] a0, input logic [31:0] a1);
        bit got;
        set_m(p, 1'b1, 1'b0, a0, 32'd0, 2'd2);
        for (int k = 0; k < 2; k++) begin
            got = 0;
            for (int c = 0; c < 60 && !got; c++) begin
                tick();
                if ((p == 0) ? m0_ack : m1_ack) got = 1;
            end
            chk(p == 0 ? "m0_grant_seen" : "m1_grant_seen", {31'd0, got}, 1);
            if (k == 0) set_m(p, 1'b1, 1'b0, a1, 32'd0, 2'd2);
            else        set_m(p, 1'b0, 1'b0, a1, 32'd0, 2'd2);
        end
    endtask

    initial begin
        bit got;
        // port, we, addr, wdata, size, delay, mem rdata, exp err, exp rdata
        vecs[0] = '{0, 1'b0, 32'h100, 32'h0,        2'd2, 3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b0, 32'h200, 32'h0,        2'd1, 0,  32'h1234ABCD, 1'b0, 32'h1234ABCD};
        vecs[2] = '{0, 1'b1, 32'h040, 32'hCAFEF00D, 2'd2, 1,  32'h11111111, 1'b0, 32'h11111111};
        vecs[3] = '{1, 1'b1, 32'h020, 32'h55,       2'd0, 99, 32'h77777777, 1'b1, 32'h0};
        vecs[4] = '{0, 1'b0, 32'h300, 32'h0,        2'd2, 4,  32'h89ABCDEF, 1'b1, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h044, 32'h0,        2'd2, 2,  32'hA5A55A5A, 1'b0, 32'hA5A55A5A};
        vecs[6] = '{0, 1'b0, 32'h008, 32'h0,        2'd1, 0,  32'h0000BEEF, 1'b0, 32'h0000BEEF};
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        // reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size", {30'd0, mem_size}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_acks", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_cpu_enable", {31'd0, cpu_enable}, 1);
        rst = 1'b0;
        tick();
        chk("idle_no_req", {31'd0, mem_req}, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // spurious mem_ack while idle
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spur_mem_req", {31'd0, mem_req}, 0);
            chk("spur_acks", {30'd0, m0_ack, m1_ack}, 0);
        end
        force_ack = 1'b0;
        tick();
        tick();
        chk("spur_m0_rdata", m0_rdata, last_rd[0]);
        chk("spur_m1_rdata", m1_rdata, last_rd[1]);

        // reset in the middle of a BUSY transaction
        resp_delay = 99;
        set_m(0, 1'b1, 1'b0, 32'h500, 32'd0, 2'd2);
        tick();
        chk("abort_busy", {31'd0, mem_req}, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_mem_req", {31'd0, mem_req}, 0);
        chk("abort_acks", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("abort_m0_rdata", m0_rdata, 0);
        chk("abort_cpu_enable", {31'd0, cpu_enable}, 0);
        rst = 1'b0;
        resp_delay = 1;
        resp_data  = 32'h600DF00D;
        sb_q.push_back('{0, 32'h600DF00D, 1'b0});
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (m0_ack) got = 1;
        end
        chk("rereq_done", {31'd0, got}, 1);
        set_m(0, 1'b0, 1'b0, 32'h500, 32'd0, 2'd2);
        tick();

        // simultaneous requests, each master holding for two transactions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_mode  = 1'b1;
        resp_delay = 1;
`ifdef ARB_ROUND_ROBIN_EN
        sb_q.push_back('{0, 32'h1000 ^ KEY, 1'b0});
        sb_q.push_back('{1, 32'h2000 ^ KEY, 1'b0});
        sb_q.push_back('{0, 32'h1004 ^ KEY, 1'b0});
        sb_q.push_back('{1, 32'h2004 ^ KEY, 1'b0});
`else
        sb_q.push_back('{0, 32'h1000 ^ KEY, 1'b0});
        sb_q.push_back('{0, 32'h1004 ^ KEY, 1'b0});
        sb_q.push_back('{1, 32'h2000 ^ KEY, 1'b0});
        sb_q.push_back('{1, 32'h2004 ^ KEY, 1'b0});
`endif
        fork
            master_seq(0, 32'h1000, 32'h1004);
            master_seq(1, 32'h2000, 32'h2004);
        join
        addr_mode = 1'b0;
        tick();
        tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the number of mem_ack wait cycles before abort (1..255).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports mN_req/mN_we  in  1 each, N=0 (CPU), 1 (secondary master)  request and write-enable.
REQ-007 SHALL have ports mN_addr  in  ADDR_WIDTH, mN_wdata  in  DATA_WIDTH, mN_size  in  2 (0=8b, 1=16b, 2=32b)  request fields.
REQ-008 SHALL have ports mN_rdata  out  DATA_WIDTH, mN_ack  out  1, mN_err  out  1  completion.
REQ-009 SHALL have ports mem_req/mem_we  out  1, mem_addr  out  ADDR_WIDTH, mem_wdata  out  DATA_WIDTH, mem_size  out  2  shared memory request.
REQ-010 SHALL have ports mem_rdata  in  DATA_WIDTH, mem_ack  in  1  memory completion.
REQ-011 SHALL have port cpu_enable  out  1  CPU stall control, wired to the CPU enable input.

Function
REQ-012 SHALL implement states IDLE, BUSY and DONE.
REQ-013 In IDLE, if any mN_req is high, SHALL latch the winner's we/addr/wdata/size into internal registers, record the winner, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-014 In BUSY, SHALL drive mem_req=1 with the latched fields; mem_* SHALL be stable throughout BUSY.
REQ-015 In BUSY with mem_ack=1, SHALL capture mem_rdata and go to DONE.
REQ-016 In DONE, SHALL assert the winner's mN_ack for exactly one cycle, drive the captured data on its mN_rdata, and return to IDLE.
REQ-017 mN_rdata SHALL hold its last value until that port's next DONE; the loser's ack/err SHALL stay 0.
REQ-018 Latency SHALL be: req high in IDLE at cycle T -> mem_req at T+1; mem_ack at cycle M -> mN_ack at M+1 -> IDLE at M+2.
REQ-019 A requester SHALL hold req and its fields stable until ack; req still high in IDLE is a new transaction (back-to-back).
REQ-020 In BUSY, an 8-bit wait counter SHALL clear on entry and increment each cycle without mem_ack.
REQ-021 When the counter reaches TIMEOUT with mem_ack=0, SHALL drop mem_req and go to DONE with mN_err=1 and mN_rdata=0.
REQ-022 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally, with no error.
REQ-023 mem_ack outside BUSY SHALL be ignored.
REQ-024 cpu_enable SHALL be combinational: 1 when m0_req=0 or m0_ack=1, else 0.
REQ-025 Requests arriving in BUSY or DONE SHALL wait; they SHALL never be dropped.

Reset
REQ-026 rst=1 SHALL force IDLE, counter=0, last-grant=1, and all outputs 0 except cpu_enable (combinational); m0_rdata, m1_rdata and mem_* fields SHALL be 0.
REQ-027 rst asserted mid-transaction SHALL abort it with no ack or err issued; mem_req SHALL be 0 on the cycle after the reset edge.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, on simultaneous m0_req and m1_req SHALL grant the port not granted last and update last-grant on every grant (m0 wins the first tie after reset).
REQ-029 Without ARB_ROUND_ROBIN_EN, m0 SHALL always win ties, and the last-grant register SHALL be omitted.

Verification
REQ-030 m0 read addr 0x100, size 2; mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF -> m0_ack one cycle later, m0_rdata=0xDEADBEEF, cpu_enable=0 until m0_ack.
REQ-031 m0 and m1 requests at the same cycle, both held for two transactions -> with macro: grants m0,m1,m0,m1; without macro: m0,m0 then m1.
REQ-032 m1 write addr 0x20, wdata 0x55, size 0; mem_ack never asserted, TIMEOUT=4 -> mem_req high 4 cycles then low, m1_ack=1 and m1_err=1, m1_rdata=0.
REQ-033 rst pulsed during BUSY -> next cycle mem_req=0, no ack; m0 re-request completes normally.
REQ-034 Spurious mem_ack in IDLE -> no state change, no ack pulses.
